// File: rtl/safety_annunciator_pkg.sv
// Shared encodings for the safety annunciator: FSM states, chime levels,
// lamp codes, warning-vector bit positions and the lamp rotation search.
package safety_annunciator_pkg;

  localparam int WARN_W = 6;

  typedef enum logic [1:0] {
    CH_IDLE  = 2'd0,
    CH_ON    = 2'd1,
    CH_OFF   = 2'd2,
    CH_MUTED = 2'd3
  } chime_state_t;

  typedef enum logic [1:0] {
    ST_READY   = 2'd0,
    ST_CRANK   = 2'd1,
    ST_LOCKOUT = 2'd2
  } starter_state_t;

  typedef enum logic [1:0] {
    LVL_NONE = 2'd0,
    LVL_PRI2 = 2'd1,
    LVL_PRI1 = 2'd2
  } chime_level_t;

  localparam logic [2:0] LAMP_NONE   = 3'd0;
  localparam logic [2:0] LAMP_SEAT   = 3'd1;
  localparam logic [2:0] LAMP_HOOD   = 3'd2;
  localparam logic [2:0] LAMP_TRUNK  = 3'd3;
  localparam logic [2:0] LAMP_BAT    = 3'd4;
  localparam logic [2:0] LAMP_AIRBAG = 3'd5;
  localparam logic [2:0] LAMP_TEMP   = 3'd6;

  localparam int WARN_SEAT   = 0;
  localparam int WARN_HOOD   = 1;
  localparam int WARN_TRUNK  = 2;
  localparam int WARN_BAT    = 3;
  localparam int WARN_AIRBAG = 4;
  localparam int WARN_TEMP   = 5;

  // First active lamp code strictly after cur, wrapping 6 -> 1; cur itself is
  // the last candidate so a lone active bit keeps being selected.
  function automatic logic [2:0] next_lamp(input logic [WARN_W-1:0] warn,
                                           input logic [2:0] cur);
    logic [2:0] res;
    logic [2:0] idx;
    int         cand;
    res = LAMP_NONE;
    for (int k = WARN_W; k >= 1; k--) begin
      cand = ((int'(cur) + k - 1) % WARN_W) + 1;
      idx  = 3'(cand - 1);
      if (warn[idx]) res = 3'(cand);
    end
    return res;
  endfunction

endpackage

// File: rtl/safety_annunciator_if.sv
// Interlock-side inputs and dashboard/starter-side outputs of the annunciator.
interface safety_annunciator_if;
  import safety_annunciator_pkg::*;

  logic              i_start_permit;
  logic              i_chime;
  logic              i_warn_pri1;
  logic              i_warn_pri2;
  logic [WARN_W-1:0] i_warn_vec;
  logic              i_ack;
  logic              i_crank_req;
  logic              o_chime_out;
  logic [2:0]        o_lamp_code;
  logic              o_lamp_pri1;
  logic              o_starter_en;

  modport slave (
    input  i_start_permit, i_chime, i_warn_pri1, i_warn_pri2, i_warn_vec,
    input  i_ack, i_crank_req,
    output o_chime_out, o_lamp_code, o_lamp_pri1, o_starter_en
  );

  modport master (
    output i_start_permit, i_chime, i_warn_pri1, i_warn_pri2, i_warn_vec,
    output i_ack, i_crank_req,
    input  o_chime_out, o_lamp_code, o_lamp_pri1, o_starter_en
  );
endinterface

// File: rtl/annunciator_tick_gen.sv
// Free-running divider producing a one-cycle tick every TICK_DIV clocks.
module annunciator_tick_gen #(
  parameter int TICK_DIV = 1000
) (
  input  logic clk,
  input  logic rst_n,
  output logic o_tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] r_count;
  logic          w_last;

  assign w_last = (r_count == CW'(TICK_DIV - 1));
  assign o_tick = w_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (w_last) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CW'(1);
    end
  end

endmodule

// File: rtl/safety_annunciator.sv
// Turns static interlock warnings into a patterned chime, a rotating warning
// lamp code and a time-limited starter enable with lockout.
module safety_annunciator
  import safety_annunciator_pkg::*;
#(
  parameter int TICK_DIV            = 1000,
  parameter int P1_ON_TICKS         = 2,
  parameter int P1_OFF_TICKS        = 2,
  parameter int P2_ON_TICKS         = 4,
  parameter int P2_OFF_TICKS        = 12,
  parameter int CHIME_TIMEOUT_TICKS = 60,
  parameter int DWELL_TICKS         = 8,
  parameter int CRANK_MAX_TICKS     = 50
) (
  input logic                 clk,
  input logic                 rst_n,
  safety_annunciator_if.slave bus
);

  localparam int SYNC_W = 12;
  localparam int PH_A   = (P1_ON_TICKS > P1_OFF_TICKS) ? P1_ON_TICKS : P1_OFF_TICKS;
  localparam int PH_B   = (P2_ON_TICKS > P2_OFF_TICKS) ? P2_ON_TICKS : P2_OFF_TICKS;
  localparam int PH_MAX = (PH_A > PH_B) ? PH_A : PH_B;
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam int EL_W   = $clog2(CHIME_TIMEOUT_TICKS + 1);
  localparam int DW_W   = $clog2(DWELL_TICKS + 1);
  localparam int CR_W   = $clog2(CRANK_MAX_TICKS + 1);

  logic              w_tick;
  logic [SYNC_W-1:0] w_raw;
  logic [SYNC_W-1:0] r_sync1;
  logic [SYNC_W-1:0] r_sync2;
  logic              w_permit;
  logic              w_chime_req;
  logic              w_pri1;
  logic              w_pri2;
  logic [WARN_W-1:0] w_warn;
  logic              w_ack;
  logic              w_crank;
  logic              r_ack_prev;
  logic [WARN_W-1:0] r_warn_prev;
  logic              w_ack_rise;
  logic              w_warn_rise;

  annunciator_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .o_tick (w_tick)
  );

  assign w_raw = {bus.i_start_permit, bus.i_chime, bus.i_warn_pri1, bus.i_warn_pri2,
                  bus.i_warn_vec, bus.i_ack, bus.i_crank_req};

  assign w_permit    = r_sync2[11];
  assign w_chime_req = r_sync2[10];
  assign w_pri1      = r_sync2[9];
  assign w_pri2      = r_sync2[8];
  assign w_warn      = r_sync2[7:2];
  assign w_ack       = r_sync2[1];
  assign w_crank     = r_sync2[0];

  assign w_ack_rise  = w_ack & ~r_ack_prev;
  assign w_warn_rise = |(w_warn & ~r_warn_prev);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1     <= '0;
      r_sync2     <= '0;
      r_ack_prev  <= 1'b0;
      r_warn_prev <= '0;
    end else begin
      r_sync1     <= w_raw;
      r_sync2     <= r_sync1;
      r_ack_prev  <= w_ack;
      r_warn_prev <= w_warn;
    end
  end

  // ---------------- chime ----------------
  chime_state_t  r_ch_state, w_ch_next;
  chime_level_t  w_level;
  logic [PH_W-1:0] r_phase, w_phase_next;
  logic [EL_W-1:0] r_elapsed, w_elapsed_next;
  logic            r_phase_pri1, w_phase_pri1_next;
  logic [PH_W-1:0] w_on_len;
  logic [PH_W-1:0] w_off_len;
  logic            w_timeout;
  logic            w_mute;
  logic            r_chime_out;

  always_comb begin
    w_level = LVL_NONE;
    if (w_pri1) begin
      w_level = LVL_PRI1;
    end else if (w_pri2 || w_chime_req) begin
      w_level = LVL_PRI2;
    end
  end

  assign w_on_len  = r_phase_pri1 ? PH_W'(P1_ON_TICKS)  : PH_W'(P2_ON_TICKS);
  assign w_off_len = r_phase_pri1 ? PH_W'(P1_OFF_TICKS) : PH_W'(P2_OFF_TICKS);

  // Timeout is taken on the very tick that completes it so a phase boundary
  // landing on the same tick cannot flash one extra on-phase.
  assign w_timeout = (r_elapsed == EL_W'(CHIME_TIMEOUT_TICKS)) ||
                     (w_tick && (r_elapsed == EL_W'(CHIME_TIMEOUT_TICKS - 1)));
  assign w_mute    = (w_level == LVL_PRI2) && (w_timeout || w_ack_rise);

  always_comb begin
    w_ch_next         = r_ch_state;
    w_phase_next      = r_phase;
    w_elapsed_next    = r_elapsed;
    w_phase_pri1_next = r_phase_pri1;
    if ((r_ch_state == CH_ON || r_ch_state == CH_OFF) && w_tick &&
        (r_elapsed != EL_W'(CHIME_TIMEOUT_TICKS))) begin
      w_elapsed_next = r_elapsed + EL_W'(1);
    end
    if (w_level == LVL_NONE) begin
      w_ch_next      = CH_IDLE;
      w_phase_next   = '0;
      w_elapsed_next = '0;
    end else begin
      case (r_ch_state)
        CH_IDLE: begin
          w_ch_next         = CH_ON;
          w_phase_next      = '0;
          w_elapsed_next    = '0;
          w_phase_pri1_next = (w_level == LVL_PRI1);
        end
        CH_ON: begin
          if (w_mute) begin
            w_ch_next = CH_MUTED;
          end else if (w_tick) begin
            if (r_phase >= w_on_len - PH_W'(1)) begin
              w_ch_next         = CH_OFF;
              w_phase_next      = '0;
              w_phase_pri1_next = (w_level == LVL_PRI1);
            end else begin
              w_phase_next = r_phase + PH_W'(1);
            end
          end
        end
        CH_OFF: begin
          if (w_mute) begin
            w_ch_next = CH_MUTED;
          end else if (w_tick) begin
            if (r_phase >= w_off_len - PH_W'(1)) begin
              w_ch_next         = CH_ON;
              w_phase_next      = '0;
              w_phase_pri1_next = (w_level == LVL_PRI1);
            end else begin
              w_phase_next = r_phase + PH_W'(1);
            end
          end
        end
        CH_MUTED: begin
          if (w_level == LVL_PRI1 || w_warn_rise) begin
            w_ch_next         = CH_ON;
            w_phase_next      = '0;
            w_elapsed_next    = '0;
            w_phase_pri1_next = (w_level == LVL_PRI1);
          end
        end
        default: w_ch_next = CH_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ch_state   <= CH_IDLE;
      r_phase      <= '0;
      r_elapsed    <= '0;
      r_phase_pri1 <= 1'b0;
      r_chime_out  <= 1'b0;
    end else begin
      r_ch_state   <= w_ch_next;
      r_phase      <= w_phase_next;
      r_elapsed    <= w_elapsed_next;
      r_phase_pri1 <= w_phase_pri1_next;
      r_chime_out  <= (w_ch_next == CH_ON);
    end
  end

  // ---------------- lamp rotation ----------------
  logic [2:0]      r_lamp, w_lamp_next;
  logic [DW_W-1:0] r_dwell, w_dwell_next;
  logic            r_lamp_pri1;

  always_comb begin
    w_lamp_next  = r_lamp;
    w_dwell_next = r_dwell;
    if (w_warn == '0) begin
      w_lamp_next  = LAMP_NONE;
      w_dwell_next = '0;
    end else if (r_lamp == LAMP_NONE || !w_warn[r_lamp - 3'd1]) begin
      w_lamp_next  = next_lamp(w_warn, r_lamp);
      w_dwell_next = '0;
    end else if (w_tick) begin
      if (r_dwell >= DW_W'(DWELL_TICKS - 1)) begin
        w_lamp_next  = next_lamp(w_warn, r_lamp);
        w_dwell_next = '0;
      end else begin
        w_dwell_next = r_dwell + DW_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lamp      <= LAMP_NONE;
      r_dwell     <= '0;
      r_lamp_pri1 <= 1'b0;
    end else begin
      r_lamp      <= w_lamp_next;
      r_dwell     <= w_dwell_next;
      r_lamp_pri1 <= w_pri1;
    end
  end

  // ---------------- starter ----------------
  starter_state_t  r_st_state, w_st_next;
  logic [CR_W-1:0] r_crank_cnt, w_crank_cnt_next;
  logic            w_crank_done;
  logic            r_starter_en;

  assign w_crank_done = w_tick && (r_crank_cnt >= CR_W'(CRANK_MAX_TICKS - 1));

  always_comb begin
    w_st_next        = r_st_state;
    w_crank_cnt_next = r_crank_cnt;
    case (r_st_state)
      ST_READY: begin
        if (w_crank && w_permit) begin
          w_st_next        = ST_CRANK;
          w_crank_cnt_next = '0;
        end
      end
      ST_CRANK: begin
        // Lockout outranks a same-cycle button release.
        if (!w_permit || w_crank_done) begin
          w_st_next = ST_LOCKOUT;
        end else if (!w_crank) begin
          w_st_next = ST_READY;
        end else if (w_tick) begin
          w_crank_cnt_next = r_crank_cnt + CR_W'(1);
        end
      end
      ST_LOCKOUT: begin
        if (!w_crank) w_st_next = ST_READY;
      end
      default: w_st_next = ST_READY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_st_state   <= ST_READY;
      r_crank_cnt  <= '0;
      r_starter_en <= 1'b0;
    end else begin
      r_st_state   <= w_st_next;
      r_crank_cnt  <= w_crank_cnt_next;
      r_starter_en <= (w_st_next == ST_CRANK);
    end
  end

  assign bus.o_chime_out  = r_chime_out;
  assign bus.o_lamp_code  = r_lamp;
  assign bus.o_lamp_pri1  = r_lamp_pri1;
  assign bus.o_starter_en = r_starter_en;

endmodule

// File: tb/tb_safety_annunciator.sv
// Directed bench for safety_annunciator with a shortened timing set:
// TICK_DIV=4, PRI1 1/1, PRI2 2/6, timeout 16, dwell 4, crank max 10.
module tb_safety_annunciator;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   n;
  int   ones;

  safety_annunciator_if bus ();

  safety_annunciator #(
    .TICK_DIV            (4),
    .P1_ON_TICKS         (1),
    .P1_OFF_TICKS        (1),
    .P2_ON_TICKS         (2),
    .P2_OFF_TICKS        (6),
    .CHIME_TIMEOUT_TICKS (16),
    .DWELL_TICKS         (4),
    .CRANK_MAX_TICKS     (10)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int k);
    for (int i = 0; i < k; i++) step();
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic check_rng(input string tag, input int got, input int lo, input int hi);
    total++;
    assert (got >= lo && got <= hi) else begin
      bad++;
      $error("FAIL %s: got=%0d expected=%0d..%0d", tag, got, lo, hi);
    end
  endtask

  function automatic logic [2:0] obs(input int sel);
    case (sel)
      0:       return {2'b00, bus.o_chime_out};
      1:       return bus.o_lamp_code;
      default: return {2'b00, bus.o_starter_en};
    endcase
  endfunction

  // Number of consecutive samples (starting now) on which output sel equals val.
  task automatic run_len(input int sel, input logic [2:0] val, input int max_n, output int cnt);
    cnt = 0;
    while (obs(sel) === val && cnt < max_n) begin
      step();
      cnt++;
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.i_start_permit = 1'b0;
    bus.i_chime       = 1'b0;
    bus.i_warn_pri1   = 1'b0;
    bus.i_warn_pri2   = 1'b0;
    bus.i_warn_vec    = 6'b000000;
    bus.i_ack         = 1'b0;
    bus.i_crank_req   = 1'b0;
    steps(3);
    check("in_reset", {bus.o_chime_out, bus.o_lamp_code, bus.o_lamp_pri1, bus.o_starter_en}, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step();
      check("reset_idle", {bus.o_chime_out, bus.o_lamp_code, bus.o_lamp_pri1, bus.o_starter_en}, 0);
    end

    // PRI2 chime: 8 on / 24 off, muted after 16 ticks
    bus.i_warn_pri2 = 1'b1;
    bus.i_chime     = 1'b1;
    steps(2);
    check("chime_lat2", bus.o_chime_out, 0);
    step();
    check("chime_lat3", bus.o_chime_out, 1);
    run_len(0, 3'd1, 20, n);
    check_rng("pri2_on_first", n, 5, 8);
    run_len(0, 3'd0, 40, n);
    check("pri2_off", n, 24);
    run_len(0, 3'd1, 20, n);
    check("pri2_on", n, 8);
    run_len(0, 3'd0, 150, n);
    check("pri2_timeout_mute", n, 150);

    bus.i_warn_vec = 6'b000010;
    steps(2);
    check("warn_rise_lat2", bus.o_chime_out, 0);
    step();
    check("warn_rise_resume", bus.o_chime_out, 1);

    // ACK mutes PRI2
    bus.i_ack = 1'b1;
    step();
    bus.i_ack = 1'b0;
    step();
    check("ack_lat2", bus.o_chime_out, 1);
    step();
    check("ack_mute", bus.o_chime_out, 0);
    run_len(0, 3'd0, 50, n);
    check("ack_stays_muted", n, 50);

    // PRI1 breaks mute, 4 on / 4 off, ACK ignored
    bus.i_warn_pri1 = 1'b1;
    steps(2);
    check("pri1_lat2", bus.o_chime_out, 0);
    step();
    check("pri1_unmute", bus.o_chime_out, 1);
    check("lamp_pri1_set", bus.o_lamp_pri1, 1);
    run_len(0, 3'd1, 10, n);
    check_rng("pri1_on_first", n, 1, 4);
    run_len(0, 3'd0, 10, n);
    check("pri1_off", n, 4);
    run_len(0, 3'd1, 10, n);
    check("pri1_on", n, 4);
    ones = 0;
    bus.i_ack = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (i == 0) bus.i_ack = 1'b0;
      if (bus.o_chime_out === 1'b1) ones++;
    end
    check("pri1_ack_ignored", ones, 20);

    // Clearing all chime sources while ON -> IDLE after 3 cycles
    run_len(0, 3'd1, 10, n);
    run_len(0, 3'd0, 10, n);
    bus.i_warn_pri1 = 1'b0;
    bus.i_warn_pri2 = 1'b0;
    bus.i_chime     = 1'b0;
    steps(2);
    check("clear_lat2", bus.o_chime_out, 1);
    step();
    check("clear_idle", bus.o_chime_out, 0);
    check("lamp_pri1_clear", bus.o_lamp_pri1, 0);
    run_len(0, 3'd0, 50, n);
    check("idle_quiet", n, 50);

    // Lamp rotation 1,3,6,1
    bus.i_warn_vec = 6'b000000;
    steps(3);
    check("lamp_none", bus.o_lamp_code, 0);
    bus.i_warn_vec = 6'b100101;
    steps(2);
    check("lamp_lat2", bus.o_lamp_code, 0);
    step();
    check("lamp_first_lowest", bus.o_lamp_code, 1);
    run_len(1, 3'd1, 20, n);
    check_rng("lamp_dwell_first", n, 13, 16);
    check("lamp_seq3", bus.o_lamp_code, 3);
    run_len(1, 3'd3, 20, n);
    check("lamp_dwell3", n, 16);
    check("lamp_seq6", bus.o_lamp_code, 6);
    run_len(1, 3'd6, 20, n);
    check("lamp_dwell6", n, 16);
    check("lamp_wrap1", bus.o_lamp_code, 1);
    run_len(1, 3'd1, 20, n);
    check("lamp_dwell1", n, 16);
    step();
    bus.i_warn_vec = 6'b100001;
    steps(2);
    check("lamp_clear_lat2", bus.o_lamp_code, 3);
    step();
    check("lamp_skip_cleared", bus.o_lamp_code, 6);
    run_len(1, 3'd6, 20, n);
    check_rng("lamp_dwell_restart", n, 13, 16);
    check("lamp_after_skip", bus.o_lamp_code, 1);
    bus.i_warn_vec = 6'b000100;
    steps(3);
    check("lamp_single", bus.o_lamp_code, 3);
    run_len(1, 3'd3, 60, n);
    check("lamp_single_hold", n, 60);
    bus.i_warn_vec = 6'b000000;
    steps(3);
    check("lamp_off", bus.o_lamp_code, 0);

    // Starter crank limit and lockout
    bus.i_crank_req    = 1'b1;
    bus.i_start_permit = 1'b1;
    steps(2);
    check("starter_lat2", bus.o_starter_en, 0);
    step();
    check("starter_on", bus.o_starter_en, 1);
    run_len(2, 3'd1, 50, n);
    check_rng("crank_limit", n, 37, 40);
    run_len(2, 3'd0, 100, n);
    check("lockout_hold", n, 100);
    bus.i_crank_req = 1'b0;
    steps(5);
    check("release_ready", bus.o_starter_en, 0);
    bus.i_crank_req = 1'b1;
    steps(2);
    check("recrank_lat2", bus.o_starter_en, 0);
    step();
    check("recrank", bus.o_starter_en, 1);

    // Permit loss while cranking
    step();
    bus.i_start_permit = 1'b0;
    steps(2);
    check("permit_lat2", bus.o_starter_en, 1);
    step();
    check("permit_drop", bus.o_starter_en, 0);
    run_len(2, 3'd0, 20, n);
    check("permit_lockout", n, 20);

    // Async reset mid-crank
    bus.i_crank_req    = 1'b0;
    bus.i_start_permit = 1'b1;
    steps(5);
    bus.i_crank_req = 1'b1;
    steps(3);
    check("crank_again", bus.o_starter_en, 1);
    steps(4);
    rst_n = 1'b0;
    #1;
    check("async_reset_starter", bus.o_starter_en, 0);
    check("async_reset_all", {bus.o_chime_out, bus.o_lamp_code, bus.o_lamp_pri1, bus.o_starter_en}, 0);
    bus.i_crank_req    = 1'b0;
    bus.i_start_permit = 1'b0;
    steps(2);
    rst_n = 1'b1;
    run_len(2, 3'd0, 10, n);
    check("post_reset_idle", n, 10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
